seg_scan_driver: RTL



---
 rtl/seg_scan_driver_pkg.sv | 8 +
 rtl/seg_scan_driver_if.sv | 19 +
 rtl/seg_scan_prescaler.sv | 13 +
 rtl/seg_scan_driver.sv | 72 +++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared display constants and the digit_sel polarity helper
package seg_scan_driver_pkg;
  localparam int DIGIT_W = 4;
  localparam int MAX_DIGITS = 8;
  function automatic logic [MAX_DIGITS-1:0] dig_off(input logic active_low);
    return {MAX_DIGITS{active_low}};
  endfunction
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: load/value/dp/blank_lz inputs and scanned display outputs; master drives value, slave scans
interface seg_scan_driver_if
  import seg_scan_driver_pkg::*;
#(parameter int NUM_DIGITS = 4);
  logic load;
  logic [DIGIT_W*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0] dp_in;
  logic blank_lz;
  logic [DIGIT_W-1:0] bcd;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic dp_out;
  logic blank;
  logic frame_done;
  logic update_pending;
  modport master (output load, value, dp_in, blank_lz,
                  input bcd, digit_sel, dp_out, blank, frame_done, update_pending);
  modport slave (input load, value, dp_in, blank_lz,
                 output bcd, digit_sel, dp_out, blank, frame_done, update_pending);
endinterface

// File: rtl/seg_scan_prescaler.sv
// seg_scan_prescaler: counts 0..DIV-1 and flags tick on the last count (clk, rst in; tick out)
module seg_scan_prescaler #(parameter int DIV = 50000) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk)
    if (rst || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-seg scan with frame-boundary commit and leading-zero blanking (clk, rst, bus slave)
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst,
  seg_scan_driver_if.slave bus
);
  localparam int VW = DIGIT_W * NUM_DIGITS;
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
  localparam logic [MAX_DIGITS-1:0] OFF = dig_off(DIG_ACTIVE_LOW != 0);
  logic tick, fb, upd, z, bl;
  logic [2:0] idx, idx_n;
  logic [VW-1:0] disp, pend, disp_n;
  logic [NUM_DIGITS-1:0] dpd, dpp, dpd_n;
  logic [MAX_DIGITS-1:0][DIGIT_W-1:0] dv;
  logic [MAX_DIGITS-1:0] dpv, lz, sel;
  seg_scan_prescaler #(.DIV(REFRESH_DIV)) u_pre (.clk(clk), .rst(rst), .tick(tick));
  // Outputs are registered from the next-state index/display so a slot shows its own digit from its first cycle.
  // A load on the frame boundary bypasses pending and lands straight in the display.
  always_comb begin
    fb = tick && idx == LAST;
    idx_n = !tick ? idx : fb ? 3'd0 : idx + 3'd1;
    disp_n = !fb ? disp : bus.load ? bus.value : upd ? pend : disp;
    dpd_n = !fb ? dpd : bus.load ? bus.dp_in : upd ? dpp : dpd;
    dv = '0;
    dv[NUM_DIGITS-1:0] = disp_n;
    dpv = '0;
    dpv[NUM_DIGITS-1:0] = dpd_n;
    z = 1'b1;
    lz = '0;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      z = z && dv[i] == '0;
      lz[i] = z;
    end
    bl = bus.blank_lz && lz[idx_n];
    sel = OFF ^ (MAX_DIGITS'(1) << idx_n);
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      disp <= '0;
      pend <= '0;
      dpd <= '0;
      dpp <= '0;
      upd <= 1'b0;
      bus.bcd <= '0;
      bus.digit_sel <= OFF[NUM_DIGITS-1:0];
      bus.dp_out <= 1'b0;
      bus.blank <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      idx <= idx_n;
      disp <= disp_n;
      dpd <= dpd_n;
      if (bus.load) begin
        pend <= bus.value;
        dpp <= bus.dp_in;
      end
      upd <= bus.load ? !fb : upd && !fb;
      bus.bcd <= dv[idx_n];
      bus.digit_sel <= bl ? OFF[NUM_DIGITS-1:0] : sel[NUM_DIGITS-1:0];
      bus.dp_out <= !bl && dpv[idx_n];
      bus.blank <= bl;
      bus.frame_done <= fb;
    end
  assign bus.update_pending = upd;
endmodule
